sfp_ctrl: RTL



---
 rtl/sfp_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sfp_ctrl.sv
// sfp_ctrl: psum SRAM / OFIFO sequencer for the special-function (accumulate/ReLU/quantize) stage.
// Walks n_rows psum rows over n_pass accumulation passes: read old psum (skipped on pass 0),
// accept one MAC row, write the accumulated psum back, and on the last pass push to the OFIFO.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, n_rows, n_pass job start pulse and its row/pass configuration
//   mac_valid, mac_ready  MAC row handshake (transfer = mac_valid & mac_ready)
//   old_psum_valid/zero   per-column accumulate strobe, zero substitution on pass 0
//   sram_cen/wen/addr     psum SRAM control (active-low enables)
//   ofifo_full, ofifo_wr  OFIFO back-pressure and push
//   busy, done            job in progress, one-cycle completion pulse
//   stall_cnt             ACC cycles without a transfer; built only with SFP_CTRL_STALL_CNT_EN
module sfp_ctrl #(
    parameter int addr_bw = 4,
    parameter int pass_bw = 4,
    parameter int col     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] n_rows,
    input  logic [pass_bw-1:0] n_pass,
    input  logic               mac_valid,
    output logic               mac_ready,
    output logic [col-1:0]     old_psum_valid,
    output logic               old_psum_zero,
    output logic               sram_cen,
    output logic               sram_wen,
    output logic [addr_bw-1:0] sram_addr,
    input  logic               ofifo_full,
    output logic               ofifo_wr,
    output logic               busy,
    output logic               done,
    output logic [15:0]        stall_cnt
);
    typedef enum logic [1:0] {IDLE, RD, ACC, FIN} state_t;
    state_t state_q, state_d;
    logic [addr_bw-1:0] row_q, row_d, rows_q, rows_d;
    logic [pass_bw-1:0] pass_q, pass_d, passes_q, passes_d;
    logic last_pass;
    assign last_pass = pass_q == passes_q - 1'b1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            pass_q   <= '0;
            rows_q   <= '0;
            passes_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            pass_q   <= pass_d;
            rows_q   <= rows_d;
            passes_q <= passes_d;
        end
    end
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        pass_d         = pass_q;
        rows_d         = rows_q;
        passes_d       = passes_q;
        mac_ready      = 1'b0;
        old_psum_valid = '0;
        old_psum_zero  = 1'b0;
        sram_cen       = 1'b1;
        sram_wen       = 1'b1;
        sram_addr      = '0;
        ofifo_wr       = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state_q)
            IDLE: begin
                // An empty job completes through FIN without ever touching the SRAM.
                if (start && n_rows != '0 && n_pass != '0) begin
                    rows_d   = n_rows;
                    passes_d = n_pass;
                    row_d    = '0;
                    pass_d   = '0;
                    state_d  = RD;
                end else if (start) begin
                    state_d = FIN;
                end
            end
            RD: begin
                busy      = 1'b1;
                sram_addr = row_q;
                sram_cen  = pass_q == '0;
                state_d   = ACC;
            end
            ACC: begin
                busy           = 1'b1;
                old_psum_valid = '1;
                old_psum_zero  = pass_q == '0;
                sram_addr      = row_q;
                // OFIFO back-pressure only matters when this pass produces activations.
                mac_ready      = last_pass ? !ofifo_full : 1'b1;
                if (mac_valid && mac_ready) begin
                    sram_cen = 1'b0;
                    sram_wen = 1'b0;
                    ofifo_wr = last_pass;
                    if (row_q == rows_q - 1'b1) begin
                        row_d   = '0;
                        pass_d  = pass_q + 1'b1;
                        state_d = last_pass ? FIN : RD;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = RD;
                    end
                end
            end
            default: begin
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end
`ifdef SFP_CTRL_STALL_CNT_EN
    logic [15:0] stall_q;
    logic        xfer;
    assign xfer = mac_valid & mac_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_q <= '0;
        else if (state_q == IDLE && start)
            stall_q <= '0;
        else if (state_q == ACC && !xfer && stall_q != 16'hFFFF)
            stall_q <= stall_q + 1'b1;
    end
    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif
endmodule
